// File: rtl/uart_word_assembler.sv
// -----------------------------------------------------------------------------
// uart_word_assembler
//
// Packs a stream of received UART bytes into 32-bit little-endian words and
// presents them on a valid/ready output port together with a sequence address.
// When the consumer stalls, one completed word can wait in the assembly register
// (state PARKED). While it waits, incoming bytes are dropped and a sticky
// overrun flag is set.
//
// Optional feature: when the macro UART_WORD_TIMEOUT_EN is defined, a partial
// word that sees TIMEOUT_CYCLES idle cycles is discarded. A one-cycle
// partial_drop pulse marks the discard. In the default build there is no idle
// counter and partial_drop is tied 0.
//
// Parameters
//   ADDR_W          width of the word sequence address (wraps)
//   TIMEOUT_CYCLES  idle cycles before a partial word is discarded
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   clr           in   synchronous clear (overrides all other inputs)
//   in_data[7:0]  in   received byte
//   in_valid      in   one-cycle strobe, in_data valid
//   word_data[31] out  assembled word
//   word_valid    out  word_data / word_addr valid
//   word_ready    in   consumer accepts the presented word this cycle
//   word_addr     out  sequence address of the presented word
//   overrun       out  sticky, a byte was dropped while PARKED
//   partial_drop  out  one-cycle pulse, a partial word was discarded
// -----------------------------------------------------------------------------
module uart_word_assembler #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic [31:0]       word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [ADDR_W-1:0] word_addr,
  output logic              overrun,
  output logic              partial_drop
);

  typedef enum logic {
    COLLECT = 1'b0,
    PARKED  = 1'b1
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [1:0]          r_idx,        w_idx_nxt;
  logic [31:0]         r_asm,        w_asm_nxt;
  logic [31:0]         r_word_data,  w_word_data_nxt;
  logic                r_word_valid, w_word_valid_nxt;
  logic [ADDR_W-1:0]   r_word_addr,  w_word_addr_nxt;
  logic                r_overrun,    w_overrun_nxt;

  logic                w_hs;
  logic                w_timeout;

  assign w_hs = r_word_valid & word_ready;

`ifdef UART_WORD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_idle, w_idle_nxt;
  logic             r_partial_drop;

  // The counter only runs while a partial word sits in COLLECT. The cycle that
  // would bring it to TIMEOUT_CYCLES fires the discard instead, so the counter
  // never needs to hold the terminal value.
  always_comb begin
    w_idle_nxt = '0;
    w_timeout  = 1'b0;
    if (r_state == COLLECT && r_idx != 2'd0 && !in_valid) begin
      if (r_idle == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        w_timeout = 1'b1;
      end else begin
        w_idle_nxt = r_idle + 1'b1;
      end
    end
    if (clr) begin
      w_idle_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle         <= '0;
      r_partial_drop <= 1'b0;
    end else begin
      r_idle         <= w_idle_nxt;
      r_partial_drop <= w_timeout & ~clr;
    end
  end

  assign partial_drop = r_partial_drop;
`else
  assign w_timeout    = 1'b0;
  assign partial_drop = 1'b0;
`endif

  // Next-state and datapath. Handshake bookkeeping comes first. Byte acceptance
  // may then reload the output in the same cycle. clr is applied last and so
  // wins over everything else.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through this
    // block leaves a signal unassigned. An unassigned path would infer a latch.
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_asm_nxt        = r_asm;
    w_word_data_nxt  = r_word_data;
    w_word_valid_nxt = r_word_valid;
    w_word_addr_nxt  = r_word_addr;
    w_overrun_nxt    = r_overrun;

    if (w_hs) begin
      w_word_addr_nxt  = r_word_addr + 1'b1;
      w_word_valid_nxt = 1'b0;
    end

    case (r_state)
      COLLECT: begin
        if (in_valid) begin
          w_asm_nxt[{r_idx, 3'b000} +: 8] = in_data;
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            // The output slot is free, or it frees up this cycle.
            if (!r_word_valid || w_hs) begin
              w_word_data_nxt  = {in_data, r_asm[23:0]};
              w_word_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = PARKED;
            end
          end
        end else if (w_timeout) begin
          w_idx_nxt = 2'd0;
          w_asm_nxt = '0;
        end
      end
      PARKED: begin
        // The index has already wrapped to 0. r_asm holds the complete word.
        if (in_valid) begin
          w_overrun_nxt = 1'b1;
        end
        if (w_hs) begin
          w_word_data_nxt  = r_asm;
          w_word_valid_nxt = 1'b1;
          w_state_nxt      = COLLECT;
          w_idx_nxt        = 2'd0;
        end
      end
    endcase

    if (clr) begin
      w_state_nxt      = COLLECT;
      w_idx_nxt        = 2'd0;
      w_asm_nxt        = '0;
      w_word_valid_nxt = 1'b0;
      w_word_addr_nxt  = '0;
      w_overrun_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= COLLECT;
      r_idx        <= 2'd0;
      r_asm        <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_word_addr  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, whatever order they appear in this block.
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_asm        <= w_asm_nxt;
      r_word_data  <= w_word_data_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_word_addr  <= w_word_addr_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign word_addr  = r_word_addr;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_word_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_word_assembler
//
// Directed testbench for uart_word_assembler. The DUT is built with ADDR_W=2,
// which exercises address wrap, and TIMEOUT_CYCLES=8. Inputs change 1 ns after
// each rising edge. Outputs are sampled at the same point, after the edge
// has settled.
// -----------------------------------------------------------------------------
module tb_uart_word_assembler;

  localparam int ADDR_W         = 2;
  localparam int TIMEOUT_CYCLES = 8;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic [7:0]        in_data;
  logic              in_valid;
  logic [31:0]       word_data;
  logic              word_valid;
  logic              word_ready;
  logic [ADDR_W-1:0] word_addr;
  logic              overrun;
  logic              partial_drop;

  int n_checks = 0;
  int n_pass   = 0;

  uart_word_assembler #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_addr   (word_addr),
    .overrun     (overrun),
    .partial_drop(partial_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  int drops;

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    word_ready = 1'b0;
    #1;
    check("rst_valid",   32'(word_valid),   32'd0);
    check("rst_data",    word_data,         32'd0);
    check("rst_addr",    32'(word_addr),    32'd0);
    check("rst_overrun", 32'(overrun),      32'd0);
    check("rst_pdrop",   32'(partial_drop), 32'd0);
    step();
    rst_n = 1'b1;

    // Basic little-endian word, consumer always ready.
    word_ready = 1'b1;
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    check("w0_valid", 32'(word_valid), 32'd1);
    check("w0_data",  word_data,       32'h12345678);
    check("w0_addr",  32'(word_addr),  32'd0);
    step();
    check("w0_drop_valid", 32'(word_valid), 32'd0);
    check("w0_next_addr",  32'(word_addr),  32'd1);

    // Back-pressure: present one word, park a second, drop five bytes.
    do_clr();
    word_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("bp_w1_valid", 32'(word_valid), 32'd1);
    check("bp_w1_data",  word_data,       32'h04030201);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    check("bp_w1_stable", word_data,      32'h04030201);
    check("bp_addr_hold", 32'(word_addr), 32'd0);
    check("bp_no_ovr",    32'(overrun),   32'd0);
    for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i));
    check("bp_overrun",  32'(overrun), 32'd1);
    check("bp_w1_still", word_data,    32'h04030201);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("bp_w2_valid", 32'(word_valid), 32'd1);
    check("bp_w2_data",  word_data,       32'h08070605);
    check("bp_w2_addr",  32'(word_addr),  32'd1);
    step();
    check("bp_ovr_sticky", 32'(overrun), 32'd1);
    word_ready = 1'b1;
    step();
    check("bp_w2_gone", 32'(word_valid), 32'd0);
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    check("bp_after_data", word_data,      32'hA3A2A1A0);
    check("bp_after_addr", 32'(word_addr), 32'd2);
    step();
    check("bp_ovr_before_clr", 32'(overrun), 32'd1);
    do_clr();
    check("bp_ovr_cleared", 32'(overrun), 32'd0);

    // Address wrap with ADDR_W=2: 0,1,2,3,0.
    word_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) send(8'(16 * w + b));
      check($sformatf("wrap_addr%0d", w), 32'(word_addr), 32'(w % 4));
      check($sformatf("wrap_data%0d", w), word_data,
            {8'(16 * w + 3), 8'(16 * w + 2), 8'(16 * w + 1), 8'(16 * w)});
    end
    step();
    do_clr();

    // Reset mid-word loses the partial bytes.
    send(8'h11); send(8'h22);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(word_valid), 32'd0);
    check("mid_rst_data",  word_data,       32'd0);
    step();
    rst_n = 1'b1;
    send(8'hAA); send(8'hBB);
    check("post_rst_no_word", 32'(word_valid), 32'd0);
    send(8'hCC); send(8'hDD);
    check("post_rst_valid", 32'(word_valid), 32'd1);
    check("post_rst_data",  word_data,       32'hDDCCBBAA);
    check("post_rst_addr",  32'(word_addr),  32'd0);
    step();
    do_clr();

    // Idle timeout on a 3-byte partial word.
    send(8'h01); send(8'h02); send(8'h03);
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (partial_drop) drops++;
    end
`ifdef UART_WORD_TIMEOUT_EN
    check("to_pulse_count", 32'(drops), 32'd1);
    send(8'h10);
    check("to_pulse_ended", 32'(partial_drop), 32'd0);
    check("to_no_word",     32'(word_valid),   32'd0);
    send(8'h20); send(8'h30); send(8'h40);
    check("to_clean_valid", 32'(word_valid), 32'd1);
    check("to_clean_data",  word_data,       32'h40302010);
`else
    check("to_pulse_count", 32'(drops), 32'd0);
    send(8'h10);
    check("to_old_valid", 32'(word_valid), 32'd1);
    check("to_old_data",  word_data,       32'h10030201);
    send(8'h20); send(8'h30); send(8'h40);
`endif
    step();
    do_clr();

    // clr together with a 4th byte overrides everything.
    word_ready = 1'b0;
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
    send(8'hFF);
    check("clr_setup_ovr", 32'(overrun), 32'd1);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("clr_setup_addr", 32'(word_addr), 32'd1);
    send(8'h91); send(8'h92); send(8'h93);
    clr        = 1'b1;
    word_ready = 1'b1;
    send(8'h94);
    clr = 1'b0;
    check("clr_valid",   32'(word_valid), 32'd0);
    check("clr_overrun", 32'(overrun),    32'd0);
    check("clr_addr",    32'(word_addr),  32'd0);
    send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
    check("clr_idx0_data", word_data,       32'hE4E3E2E1);
    check("clr_idx0_addr", 32'(word_addr),  32'd0);
    check("clr_pdrop",     32'(partial_drop), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
